divider_share_arbiter: RTL and testbench

- Round-robin arbiter that time-shares one streamlined_divider_4bit among N_REQ requesters.
- Each requester uses the divider's own protocol: hold start_sig high until a one-cycle done pulse, then drop it.
- The block sequences the divider's start_sig/dong_sig handshake and short-circuits divide-by-zero.
- It returns quotient/reminder on a shared result bus, plus a per-requester done pulse and an error flag.
- Sits between the requesting controllers and the single divider instance.

---
 rtl/divider_share_arbiter.sv | 139 +++++++++++++
 tb/tb_divider_share_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_share_arbiter.sv
// Round-robin arbiter that time-shares one divider among N_REQ level requesters.
// Divide-by-zero is answered locally and a stalled divider is aborted after TIMEOUT cycles.
//
// state | meaning
// IDLE  | waiting for a request; round-robin pick and operand latch on grant
// RUN   | divider started, waiting for div_dong_sig or timeout
// DONE  | one-cycle completion pulse to the granted requester
module divider_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_start_sig,
  input  logic [N_REQ*DATA_W-1:0]   req_dividend,
  input  logic [N_REQ*DATA_W-1:0]   req_divisor,
  output logic [N_REQ-1:0]          req_done_sig,
  output logic [DATA_W-1:0]         res_quotient,
  output logic [DATA_W-1:0]         res_reminder,
  output logic                      res_err_sig,
  output logic [2:0]                grant_id,
  output logic                      busy_sig,
  output logic                      div_start_sig,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic                      div_dong_sig,
  input  logic [DATA_W-1:0]         div_quotient,
  input  logic [DATA_W-1:0]         div_reminder
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [CNT_W-1:0]  cnt;

  logic              found;
  logic [2:0]        sel;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // First set request bit searching upward from ptr+1, wrapping at N_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = ptr;
    sel_a = '0;
    sel_b = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req_start_sig[idx]) begin
        found = 1'b1;
        sel   = 3'(idx);
        sel_a = req_dividend[idx*DATA_W +: DATA_W];
        sel_b = req_divisor[idx*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 3'(N_REQ - 1);
      cnt           <= '0;
      req_done_sig  <= '0;
      res_quotient  <= '0;
      res_reminder  <= '0;
      res_err_sig   <= 1'b0;
      grant_id      <= '0;
      busy_sig      <= 1'b0;
      div_start_sig <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      req_done_sig <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id     <= sel;
            ptr          <= sel;
            div_dividend <= sel_a;
            div_divisor  <= sel_b;
            cnt          <= '0;
            busy_sig     <= 1'b1;
            if (sel_b != '0) begin
              div_start_sig <= 1'b1;
              state         <= RUN;
            end else begin
              // Divide-by-zero never reaches the divider.
              res_quotient <= '1;
              res_reminder <= sel_a;
              res_err_sig  <= 1'b1;
              req_done_sig <= ONE_HOT0 << sel;
              state        <= DONE;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (div_dong_sig) begin
            res_quotient  <= div_quotient;
            res_reminder  <= div_reminder;
            res_err_sig   <= 1'b0;
            div_start_sig <= 1'b0;
            req_done_sig  <= ONE_HOT0 << grant_id;
            state         <= DONE;
          end else if (cnt == CNT_LAST) begin
            res_quotient  <= '0;
            res_reminder  <= '0;
            res_err_sig   <= 1'b1;
            div_start_sig <= 1'b0;
            req_done_sig  <= ONE_HOT0 << grant_id;
            state         <= DONE;
          end
        end
        DONE: begin
          busy_sig <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_sig      <= 1'b0;
          div_start_sig <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_share_arbiter.sv
// Directed bench for divider_share_arbiter with a behavioural divider
// (fixed latency, optional mute to force the timeout path).
module tb_divider_share_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 4;
  localparam int TIMEOUT = 15;
  localparam int DIV_LAT = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_start_sig;
  logic [N_REQ*DATA_W-1:0] req_dividend;
  logic [N_REQ*DATA_W-1:0] req_divisor;
  logic [N_REQ-1:0]        req_done_sig;
  logic [DATA_W-1:0]       res_quotient;
  logic [DATA_W-1:0]       res_reminder;
  logic                    res_err_sig;
  logic [2:0]              grant_id;
  logic                    busy_sig;
  logic                    div_start_sig;
  logic [DATA_W-1:0]       div_dividend;
  logic [DATA_W-1:0]       div_divisor;
  logic                    div_dong_sig;
  logic [DATA_W-1:0]       div_quotient;
  logic [DATA_W-1:0]       div_reminder;

  divider_share_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_start_sig(req_start_sig), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_done_sig(req_done_sig), .res_quotient(res_quotient), .res_reminder(res_reminder),
    .res_err_sig(res_err_sig), .grant_id(grant_id), .busy_sig(busy_sig),
    .div_start_sig(div_start_sig), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_dong_sig(div_dong_sig), .div_quotient(div_quotient), .div_reminder(div_reminder)
  );

  always #5 clk = ~clk;

  // Behavioural divider: dong pulses after DIV_LAT sampled starts, then waits for start to drop.
  logic       mute;
  logic [2:0] dcnt;
  logic       dfin;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_dong_sig <= 1'b0;
      div_quotient <= '0;
      div_reminder <= '0;
      dcnt         <= '0;
      dfin         <= 1'b0;
    end else begin
      div_dong_sig <= 1'b0;
      if (!div_start_sig) begin
        dfin <= 1'b0;
        dcnt <= '0;
      end else if (!dfin && !mute) begin
        if (dcnt == 3'(DIV_LAT - 1)) begin
          div_dong_sig <= 1'b1;
          dfin         <= 1'b1;
          dcnt         <= '0;
          div_quotient <= div_dividend / div_divisor;
          div_reminder <= div_dividend % div_divisor;
        end else begin
          dcnt <= dcnt + 3'd1;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_starts = 0;
  logic start_prev = 1'b0;
  int remaining [N_REQ];
  int ev_id[$], ev_q[$], ev_r[$], ev_err[$], ev_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    ev_id.delete(); ev_q.delete(); ev_r.delete(); ev_err.delete(); ev_cyc.delete();
  endtask

  task automatic req(input int k, input logic [3:0] a, input logic [3:0] b, input int n);
    req_dividend[k*DATA_W +: DATA_W] = a;
    req_divisor[k*DATA_W +: DATA_W]  = b;
    remaining[k]     = n;
    req_start_sig[k] = 1'b1;
  endtask

  // One clock: sample #1 after the edge, log completions, let requesters drop on done.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (req_done_sig != '0) begin
      check("done_onehot", 32'($onehot(req_done_sig)), 1);
      check("done_matches_grant", 32'((req_done_sig >> grant_id) & 4'd1), 1);
      check("start_low_at_done", 32'(div_start_sig), 0);
      ev_id.push_back(int'(grant_id));
      ev_q.push_back(int'(res_quotient));
      ev_r.push_back(int'(res_reminder));
      ev_err.push_back(int'(res_err_sig));
      ev_cyc.push_back(cyc);
      for (int k = 0; k < N_REQ; k++) begin
        if (req_done_sig[k]) begin
          remaining[k]--;
          if (remaining[k] <= 0) req_start_sig[k] = 1'b0;
        end
      end
    end
    if (div_start_sig && !start_prev) n_starts++;
    start_prev = div_start_sig;
  endtask

  task automatic wait_ev(input int n, input int budget);
    int b;
    b = 0;
    while (ev_id.size() < n && b < budget) begin
      tick();
      b++;
    end
    check("event_count", 32'(ev_id.size()), 32'(n));
  endtask

  function automatic logic [25:0] all_outs();
    return {req_done_sig, res_quotient, res_reminder, res_err_sig, grant_id,
            busy_sig, div_start_sig, div_dividend, div_divisor};
  endfunction

  initial begin
    int c0;
    int s0;
    int exp_id [4];
    int exp_q  [4];
    int exp_r  [4];

    rst_n = 1'b0;
    mute = 1'b0;
    req_start_sig = '0;
    req_dividend = '0;
    req_divisor = '0;
    for (int k = 0; k < N_REQ; k++) remaining[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(all_outs()), 0);
    rst_n = 1'b1;
    tick(); tick();

    // All four requesters at once: grants 0,1,2,3 from reset pointer.
    clear_log();
    req(0, 4'd7, 4'd2, 1);
    req(1, 4'd9, 4'd3, 1);
    req(2, 4'd15, 4'd4, 1);
    req(3, 4'd5, 4'd5, 1);
    wait_ev(4, 60);
    exp_id = '{0, 1, 2, 3};
    exp_q  = '{3, 3, 3, 1};
    exp_r  = '{1, 0, 3, 0};
    for (int i = 0; i < 4 && i < ev_id.size(); i++) begin
      check("all4_id", 32'(ev_id[i]), 32'(exp_id[i]));
      check("all4_quot", 32'(ev_q[i]), 32'(exp_q[i]));
      check("all4_rem", 32'(ev_r[i]), 32'(exp_r[i]));
      check("all4_err", 32'(ev_err[i]), 0);
    end
    tick(); tick();

    // Requesters 0 and 2 hold continuously: alternate 0,2,0,2.
    clear_log();
    req(0, 4'd8, 4'd3, 2);
    req(2, 4'd14, 4'd5, 2);
    wait_ev(4, 60);
    exp_id = '{0, 2, 0, 2};
    exp_q  = '{2, 2, 2, 2};
    exp_r  = '{2, 4, 2, 4};
    for (int i = 0; i < 4 && i < ev_id.size(); i++) begin
      check("rr_id", 32'(ev_id[i]), 32'(exp_id[i]));
      check("rr_quot", 32'(ev_q[i]), 32'(exp_q[i]));
      check("rr_rem", 32'(ev_r[i]), 32'(exp_r[i]));
    end
    tick(); tick();

    // Single 7/2 from requester 0; operand change after grant is ignored.
    clear_log();
    c0 = cyc;
    req(0, 4'd7, 4'd2, 1);
    tick(); tick();
    check("busy_in_run", 32'(busy_sig), 1);
    req_dividend[3:0] = 4'd0;
    check("div_dividend_latched", 32'(div_dividend), 7);
    wait_ev(1, 20);
    if (ev_id.size() >= 1) begin
      check("single_id", 32'(ev_id[0]), 0);
      check("single_quot", 32'(ev_q[0]), 3);
      check("single_rem", 32'(ev_r[0]), 1);
      check("single_err", 32'(ev_err[0]), 0);
      check("single_latency", 32'(ev_cyc[0] - c0), 32'(DIV_LAT + 2));
    end
    tick();
    check("idle_after_done", 32'({busy_sig, req_done_sig}), 0);
    tick();

    // Divide-by-zero from requester 1: answered locally, divider never started.
    clear_log();
    s0 = n_starts;
    c0 = cyc;
    req(1, 4'd6, 4'd0, 1);
    wait_ev(1, 10);
    if (ev_id.size() >= 1) begin
      check("dz_id", 32'(ev_id[0]), 1);
      check("dz_quot", 32'(ev_q[0]), 32'hF);
      check("dz_rem", 32'(ev_r[0]), 6);
      check("dz_err", 32'(ev_err[0]), 1);
      check("dz_latency", 32'(ev_cyc[0] - c0), 1);
    end
    tick(); tick();
    check("dz_no_start", 32'(n_starts - s0), 0);

    // Muted divider: timeout abort after TIMEOUT cycles in RUN.
    clear_log();
    mute = 1'b1;
    c0 = cyc;
    req(3, 4'd9, 4'd2, 1);
    wait_ev(1, 3 * TIMEOUT);
    if (ev_id.size() >= 1) begin
      check("to_id", 32'(ev_id[0]), 3);
      check("to_quot", 32'(ev_q[0]), 0);
      check("to_rem", 32'(ev_r[0]), 0);
      check("to_err", 32'(ev_err[0]), 1);
      check("to_latency", 32'(ev_cyc[0] - c0), 32'(TIMEOUT + 1));
    end
    mute = 1'b0;
    tick(); tick();

    // Next request after a timeout is served normally.
    clear_log();
    c0 = cyc;
    req(2, 4'd13, 4'd4, 1);
    wait_ev(1, 20);
    if (ev_id.size() >= 1) begin
      check("post_to_id", 32'(ev_id[0]), 2);
      check("post_to_quot", 32'(ev_q[0]), 3);
      check("post_to_rem", 32'(ev_r[0]), 1);
      check("post_to_err", 32'(ev_err[0]), 0);
      check("post_to_latency", 32'(ev_cyc[0] - c0), 32'(DIV_LAT + 2));
    end
    tick(); tick();

    // Reset in the middle of RUN clears outputs without waiting for an edge.
    clear_log();
    req(1, 4'd9, 4'd2, 1);
    tick(); tick();
    check("pre_reset_start", 32'(div_start_sig), 1);
    rst_n = 1'b0;
    req_start_sig = '0;
    for (int k = 0; k < N_REQ; k++) remaining[k] = 0;
    #1;
    check("async_reset_outputs", 32'(all_outs()), 0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    req(3, 4'd12, 4'd3, 1);
    req(0, 4'd0, 4'd3, 1);
    wait_ev(2, 40);
    if (ev_id.size() >= 2) begin
      check("post_rst_first_id", 32'(ev_id[0]), 0);
      check("post_rst_first_quot", 32'(ev_q[0]), 0);
      check("post_rst_first_rem", 32'(ev_r[0]), 0);
      check("post_rst_second_id", 32'(ev_id[1]), 3);
      check("post_rst_second_quot", 32'(ev_q[1]), 4);
    end
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
